// File: rtl/pa_ifu_pre_decd_pipe.sv
// Purpose  : IFU pre-decoder. Finds instruction boundaries in a fetch packet, including 32-bit
//            instructions that straddle packets, and reports the first control-flow instruction.
// Latency  : 1 cycle from an accepted fetch packet to pd_vld.
// Backpress: fetch_rdy = ~ifu_flush & (~pd_vld | pd_rdy); pd_* hold while pd_vld & ~pd_rdy.
// Ports    : forever_cpuclk/cpurst (sync, active-high) ; ifu_flush redirect ;
//            fetch_* valid/ready packet input ; pd_* registered decode result, valid/ready output.
module pa_ifu_pre_decd_pipe #(
    parameter  int NUM_HW   = 4,
    parameter  int ADDR_W   = 32,
    localparam int HW_IDX_W = $clog2(NUM_HW)
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic                   ifu_flush,
    input  logic                   fetch_vld,
    output logic                   fetch_rdy,
    input  logic [16*NUM_HW-1:0]   fetch_data,
    input  logic [ADDR_W-1:0]      fetch_pc,
    input  logic [HW_IDX_W-1:0]    fetch_start_hw,
    output logic                   pd_vld,
    input  logic                   pd_rdy,
    output logic [ADDR_W-1:0]      pd_pc,
    output logic [NUM_HW-1:0]      pd_start_mask,
    output logic                   pd_carry_vld,
    output logic [31:0]            pd_carry_inst,
    output logic                   pd_cf_vld,
    output logic                   pd_cf_carry,
    output logic [HW_IDX_W-1:0]    pd_cf_idx,
    output logic [2:0]             pd_cf_type,
    output logic                   pd_cf_inst32,
    output logic [31:0]            pd_cf_imm,
    output logic [ADDR_W-1:0]      pd_cf_tgt
);

    localparam logic [2:0] CF_NONE = 3'd0;
    localparam logic [2:0] CF_BR   = 3'd1;
    localparam logic [2:0] CF_JMP  = 3'd2;
    localparam logic [2:0] CF_LINK = 3'd3;
    localparam logic [2:0] CF_RET  = 3'd4;
    localparam logic [2:0] CF_IND  = 3'd5;

    typedef enum logic {PEND_EMPTY, PEND_FULL} pend_state_e;

    typedef struct packed {
        logic [2:0]  typ;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t dec32(input logic [31:0] in);
        dec_t r;
        r = '0;
        case (in[6:0])
            7'b1100011: begin
                r.typ = CF_BR;
                r.imm = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
            end
            7'b1101111: begin
                r.typ = (in[11:7] == 5'd1) ? CF_LINK : CF_JMP;
                r.imm = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
            end
            7'b1100111: begin
                if (in[11:7] == 5'd1)
                    r.typ = CF_IND;
                else if (in[19:15] == 5'd1)
                    r.typ = CF_RET;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic dec_t dec16(input logic [15:0] h);
        dec_t r;
        r = '0;
        case ({h[15:13], h[1:0]})
            5'b110_01, 5'b111_01: begin
                r.typ = CF_BR;
                r.imm = {{24{h[12]}}, h[6:5], h[2], h[11:10], h[4:3], 1'b0};
            end
            5'b101_01, 5'b001_01: begin
                r.typ = (h[15:13] == 3'b001) ? CF_LINK : CF_JMP;
                r.imm = {{21{h[12]}}, h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3], 1'b0};
            end
            default: begin
                if (h[6:0] == 7'b0000010) begin
                    if (h[15:12] == 4'b1000 && h[11:7] == 5'd1)
                        r.typ = CF_RET;
                    else if (h[15:12] == 4'b1001 && h[11:7] != 5'd0)
                        r.typ = CF_IND;
                end
            end
        endcase
        return r;
    endfunction

    pend_state_e         state_q, state_d;
    logic [15:0]         pend_hw_q, pend_hw_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;

    logic                pd_vld_q;
    logic [ADDR_W-1:0]   pd_pc_q;
    logic [NUM_HW-1:0]   mask_q, mask_d;
    logic                carry_q, carry_d;
    logic [31:0]         carry_inst_q, carry_inst_d;
    logic                cf_vld_q, cf_vld_d;
    logic                cf_carry_q, cf_carry_d;
    logic [HW_IDX_W-1:0] cf_idx_q, cf_idx_d;
    logic [2:0]          cf_type_q, cf_type_d;
    logic                cf_inst32_q, cf_inst32_d;
    logic [31:0]         cf_imm_q, cf_imm_d;
    logic [ADDR_W-1:0]   cf_tgt_q, cf_tgt_d;

    // One extra zero halfword so the i+1 lookup at the last slot stays in range.
    logic [15:0]         hw_x [NUM_HW+1];
    logic [HW_IDX_W-1:0] walk_start;
    logic [ADDR_W-1:0]   cf_pc;
    logic                pend_cap;
    logic                skip;
    logic                fetch_accept;
    dec_t                d;

    assign fetch_rdy    = ~ifu_flush & (~pd_vld_q | pd_rdy);
    assign fetch_accept = fetch_vld & fetch_rdy;

    // Boundary walk and first-CF selection for the packet offered this cycle.
    always_comb begin
        for (int i = 0; i < NUM_HW; i++)
            hw_x[i] = fetch_data[16*i +: 16];
        hw_x[NUM_HW] = 16'h0000;

        mask_d       = '0;
        carry_d      = 1'b0;
        carry_inst_d = '0;
        cf_vld_d     = 1'b0;
        cf_carry_d   = 1'b0;
        cf_idx_d     = '0;
        cf_type_d    = CF_NONE;
        cf_inst32_d  = 1'b0;
        cf_imm_d     = '0;
        cf_pc        = '0;
        pend_cap     = 1'b0;
        skip         = 1'b0;
        d            = '0;
        walk_start   = fetch_start_hw;

        // A pending half only joins hw0 when the packet continues sequentially.
        if (state_q == PEND_FULL && fetch_start_hw == '0) begin
            carry_d      = 1'b1;
            carry_inst_d = {hw_x[0], pend_hw_q};
            walk_start   = HW_IDX_W'(1);
            d            = dec32({hw_x[0], pend_hw_q});
            if (d.typ != CF_NONE) begin
                cf_vld_d    = 1'b1;
                cf_carry_d  = 1'b1;
                cf_type_d   = d.typ;
                cf_inst32_d = 1'b1;
                cf_imm_d    = d.imm;
                cf_pc       = pend_pc_q;
            end
        end

        for (int i = 0; i < NUM_HW; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (i >= int'(walk_start)) begin
                if (hw_x[i][1:0] == 2'b11) begin
                    if (i == NUM_HW - 1) begin
                        pend_cap = 1'b1;
                    end else begin
                        skip = 1'b1;
                        // Starts after the first CF are masked off; the walk still runs
                        // so the trailing half is captured.
                        if (!cf_vld_d) begin
                            mask_d[i] = 1'b1;
                            d         = dec32({hw_x[i+1], hw_x[i]});
                            if (d.typ != CF_NONE) begin
                                cf_vld_d    = 1'b1;
                                cf_idx_d    = HW_IDX_W'(i);
                                cf_type_d   = d.typ;
                                cf_inst32_d = 1'b1;
                                cf_imm_d    = d.imm;
                                cf_pc       = fetch_pc + ADDR_W'(2*i);
                            end
                        end
                    end
                end else if (!cf_vld_d) begin
                    mask_d[i] = 1'b1;
                    d         = dec16(hw_x[i]);
                    if (d.typ != CF_NONE) begin
                        cf_vld_d    = 1'b1;
                        cf_idx_d    = HW_IDX_W'(i);
                        cf_type_d   = d.typ;
                        cf_inst32_d = 1'b0;
                        cf_imm_d    = d.imm;
                        cf_pc       = fetch_pc + ADDR_W'(2*i);
                    end
                end
            end
        end

        // Only direct forms carry an offset; indirect forms report a zero target.
        if (cf_type_d == CF_BR || cf_type_d == CF_JMP || cf_type_d == CF_LINK)
            cf_tgt_d = cf_pc + ADDR_W'($signed(cf_imm_d));
        else
            cf_tgt_d = '0;
    end

    // Pending-half state machine: next state.
    always_comb begin
        state_d   = state_q;
        pend_hw_d = pend_hw_q;
        pend_pc_d = pend_pc_q;
        if (ifu_flush) begin
            state_d = PEND_EMPTY;
        end else if (fetch_accept) begin
            state_d = pend_cap ? PEND_FULL : PEND_EMPTY;
            if (pend_cap) begin
                pend_hw_d = hw_x[NUM_HW-1];
                pend_pc_d = fetch_pc + ADDR_W'(2*(NUM_HW-1));
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q   <= PEND_EMPTY;
            pend_hw_q <= '0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_hw_q <= pend_hw_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || ifu_flush) begin
            pd_vld_q     <= 1'b0;
            pd_pc_q      <= '0;
            mask_q       <= '0;
            carry_q      <= 1'b0;
            carry_inst_q <= '0;
            cf_vld_q     <= 1'b0;
            cf_carry_q   <= 1'b0;
            cf_idx_q     <= '0;
            cf_type_q    <= CF_NONE;
            cf_inst32_q  <= 1'b0;
            cf_imm_q     <= '0;
            cf_tgt_q     <= '0;
        end else if (fetch_accept) begin
            pd_vld_q     <= 1'b1;
            pd_pc_q      <= fetch_pc;
            mask_q       <= mask_d;
            carry_q      <= carry_d;
            carry_inst_q <= carry_inst_d;
            cf_vld_q     <= cf_vld_d;
            cf_carry_q   <= cf_carry_d;
            cf_idx_q     <= cf_idx_d;
            cf_type_q    <= cf_type_d;
            cf_inst32_q  <= cf_inst32_d;
            cf_imm_q     <= cf_imm_d;
            cf_tgt_q     <= cf_tgt_d;
        end else if (pd_rdy) begin
            pd_vld_q     <= 1'b0;
        end
    end

    assign pd_vld        = pd_vld_q;
    assign pd_pc         = pd_pc_q;
    assign pd_start_mask = mask_q;
    assign pd_carry_vld  = carry_q;
    assign pd_carry_inst = carry_inst_q;
    assign pd_cf_vld     = cf_vld_q;
    assign pd_cf_carry   = cf_carry_q;
    assign pd_cf_idx     = cf_idx_q;
    assign pd_cf_type    = cf_type_q;
    assign pd_cf_inst32  = cf_inst32_q;
    assign pd_cf_imm     = cf_imm_q;
    assign pd_cf_tgt     = cf_tgt_q;

endmodule

// File: tb/tb_pa_ifu_pre_decd_pipe.sv
// Purpose  : Self-checking bench for pa_ifu_pre_decd_pipe (NUM_HW=4, ADDR_W=32).
// Latency  : expects each accepted packet on pd_* one cycle later.
// Backpress: exercises pd_rdy stalls and ifu_flush while an entry is held.
module tb_pa_ifu_pre_decd_pipe;

    logic        forever_cpuclk;
    logic        cpurst;
    logic        ifu_flush;
    logic        fetch_vld;
    logic        fetch_rdy;
    logic [63:0] fetch_data;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_start_hw;
    logic        pd_vld;
    logic        pd_rdy;
    logic [31:0] pd_pc;
    logic [3:0]  pd_start_mask;
    logic        pd_carry_vld;
    logic [31:0] pd_carry_inst;
    logic        pd_cf_vld;
    logic        pd_cf_carry;
    logic [1:0]  pd_cf_idx;
    logic [2:0]  pd_cf_type;
    logic        pd_cf_inst32;
    logic [31:0] pd_cf_imm;
    logic [31:0] pd_cf_tgt;

    pa_ifu_pre_decd_pipe #(.NUM_HW(4), .ADDR_W(32)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .ifu_flush      (ifu_flush),
        .fetch_vld      (fetch_vld),
        .fetch_rdy      (fetch_rdy),
        .fetch_data     (fetch_data),
        .fetch_pc       (fetch_pc),
        .fetch_start_hw (fetch_start_hw),
        .pd_vld         (pd_vld),
        .pd_rdy         (pd_rdy),
        .pd_pc          (pd_pc),
        .pd_start_mask  (pd_start_mask),
        .pd_carry_vld   (pd_carry_vld),
        .pd_carry_inst  (pd_carry_inst),
        .pd_cf_vld      (pd_cf_vld),
        .pd_cf_carry    (pd_cf_carry),
        .pd_cf_idx      (pd_cf_idx),
        .pd_cf_type     (pd_cf_type),
        .pd_cf_inst32   (pd_cf_inst32),
        .pd_cf_imm      (pd_cf_imm),
        .pd_cf_tgt      (pd_cf_tgt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  mask;
        logic        carry_vld;
        logic [31:0] carry_inst;
        logic        cf_vld;
        logic        cf_carry;
        logic [1:0]  cf_idx;
        logic [2:0]  cf_type;
        logic        cf_inst32;
        logic [31:0] cf_imm;
        logic [31:0] cf_tgt;
    } exp_t;

    exp_t act;
    assign act = {pd_pc, pd_start_mask, pd_carry_vld, pd_carry_inst, pd_cf_vld, pd_cf_carry,
                  pd_cf_idx, pd_cf_type, pd_cf_inst32, pd_cf_imm, pd_cf_tgt};

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q[$];
    bit          m_full   = 0;
    logic [15:0] m_hw     = '0;
    logic [31:0] m_pc     = '0;
    bit          zero_exp = 1;

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic chk_e(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got pc=%h mask=%b carry=%b/%h cf=%b carry_cf=%b idx=%0d type=%0d w32=%b imm=%h tgt=%h | required pc=%h mask=%b carry=%b/%h cf=%b carry_cf=%b idx=%0d type=%0d w32=%b imm=%h tgt=%h",
                     name, got.pc, got.mask, got.carry_vld, got.carry_inst, got.cf_vld, got.cf_carry,
                     got.cf_idx, got.cf_type, got.cf_inst32, got.cf_imm, got.cf_tgt,
                     want.pc, want.mask, want.carry_vld, want.carry_inst, want.cf_vld, want.cf_carry,
                     want.cf_idx, want.cf_type, want.cf_inst32, want.cf_imm, want.cf_tgt);
        end
    endtask

    // ISA-level classification; offsets assembled arithmetically from their scattered fields.
    function automatic void classify(input logic [31:0] inst, input bit w32,
                                     output logic [2:0] t, output int imm);
        logic [15:0] h;
        t   = 3'd0;
        imm = 0;
        h   = inst[15:0];
        if (w32) begin
            if (inst[6:0] == 7'h63) begin
                t   = 3'd1;
                imm = (int'(inst[11:8]) << 1) + (int'(inst[30:25]) << 5)
                    + (int'(inst[7]) << 11) - (int'(inst[31]) << 12);
            end else if (inst[6:0] == 7'h6F) begin
                t   = (inst[11:7] == 5'd1) ? 3'd3 : 3'd2;
                imm = (int'(inst[30:21]) << 1) + (int'(inst[20]) << 11)
                    + (int'(inst[19:12]) << 12) - (int'(inst[31]) << 20);
            end else if (inst[6:0] == 7'h67) begin
                if (inst[11:7] == 5'd1)       t = 3'd5;
                else if (inst[19:15] == 5'd1) t = 3'd4;
            end
        end else begin
            if (h[1:0] == 2'b01 && (h[15:13] == 3'b110 || h[15:13] == 3'b111)) begin
                t   = 3'd1;
                imm = (int'(h[4:3]) << 1) + (int'(h[11:10]) << 3) + (int'(h[2]) << 5)
                    + (int'(h[6:5]) << 6) - (int'(h[12]) << 8);
            end else if (h[1:0] == 2'b01 && (h[15:13] == 3'b101 || h[15:13] == 3'b001)) begin
                t   = (h[15:13] == 3'b001) ? 3'd3 : 3'd2;
                imm = (int'(h[5:3]) << 1) + (int'(h[11]) << 4) + (int'(h[2]) << 5)
                    + (int'(h[7]) << 6) + (int'(h[6]) << 7) + (int'(h[10:9]) << 8)
                    + (int'(h[8]) << 10) - (int'(h[12]) << 11);
            end else if (h[6:0] == 7'b0000010 && h[11:7] != 5'd0) begin
                if (h[15:12] == 4'b1000 && h[11:7] == 5'd1) t = 3'd4;
                else if (h[15:12] == 4'b1001)             t = 3'd5;
            end
        end
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [63:0] d, input int st,
                                   input bit pf, input logic [15:0] ph, input logic [31:0] ppc,
                                   output bit npf, output logic [15:0] nph, output logic [31:0] nppc);
        exp_t        e;
        logic [15:0] hw [5];
        int          pos;
        bit          found;
        bit          w32;
        logic [2:0]  t;
        int          imm;
        e     = '0;
        npf   = 0;
        nph   = ph;
        nppc  = ppc;
        found = 0;
        for (int k = 0; k < 4; k++) hw[k] = d[16*k +: 16];
        hw[4] = '0;
        e.pc  = pc;
        pos   = st;
        if (pf && st == 0) begin
            e.carry_vld  = 1'b1;
            e.carry_inst = {hw[0], ph};
            pos          = 1;
            classify(e.carry_inst, 1'b1, t, imm);
            if (t != 0) begin
                found       = 1;
                e.cf_vld    = 1'b1;
                e.cf_carry  = 1'b1;
                e.cf_type   = t;
                e.cf_inst32 = 1'b1;
                if (t <= 3) begin
                    e.cf_imm = imm;
                    e.cf_tgt = ppc + imm;
                end
            end
        end
        while (pos < 4) begin
            w32 = (hw[pos][1:0] == 2'b11);
            if (w32 && pos == 3) begin
                npf  = 1;
                nph  = hw[3];
                nppc = pc + 6;
                break;
            end
            if (!found) begin
                e.mask[pos] = 1'b1;
                classify({hw[pos+1], hw[pos]}, w32, t, imm);
                if (t != 0) begin
                    found       = 1;
                    e.cf_vld    = 1'b1;
                    e.cf_idx    = 2'(pos);
                    e.cf_type   = t;
                    e.cf_inst32 = w32;
                    if (t <= 3) begin
                        e.cf_imm = imm;
                        e.cf_tgt = pc + 2*pos + imm;
                    end
                end
            end
            pos += w32 ? 2 : 1;
        end
        return e;
    endfunction

    // Scoreboard: the output register must always hold the oldest un-drained accepted packet.
    always @(negedge forever_cpuclk) begin
        exp_t        e;
        bit          npf;
        logic [15:0] nph;
        logic [31:0] nppc;
        if (cpurst) begin
            q.delete();
            m_full   = 0;
            zero_exp = 1;
        end else begin
            chk("pd_vld_vs_model", 64'(pd_vld), 64'(q.size() != 0));
            if (q.size() != 0)
                chk_e("entry", act, q[0]);
            else if (zero_exp)
                chk_e("cleared", act, '0);
            if (ifu_flush) begin
                chk("flush_fetch_rdy", 64'(fetch_rdy), 64'(0));
                q.delete();
                m_full   = 0;
                zero_exp = 1;
            end else begin
                if (pd_vld && pd_rdy && q.size() != 0) void'(q.pop_front());
                if (fetch_vld && fetch_rdy) begin
                    e = model(fetch_pc, fetch_data, int'(fetch_start_hw), m_full, m_hw, m_pc,
                              npf, nph, nppc);
                    q.push_back(e);
                    m_full   = npf;
                    m_hw     = nph;
                    m_pc     = nppc;
                    zero_exp = 0;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the packet.
    task automatic send(input logic [31:0] pc, input logic [63:0] data, input logic [1:0] st);
        fetch_pc       = pc;
        fetch_data     = data;
        fetch_start_hw = st;
        fetch_vld      = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge forever_cpuclk);
            if (fetch_rdy) begin
                @(posedge forever_cpuclk);
                #1;
                fetch_vld = 1'b0;
                return;
            end
        end
        chk("send_timeout", 64'(0), 64'(1));
        fetch_vld = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge forever_cpuclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        bit          npf;
        logic [15:0] nph;
        logic [31:0] nppc;

        cpurst         = 1'b1;
        ifu_flush      = 1'b0;
        fetch_vld      = 1'b0;
        fetch_data     = '0;
        fetch_pc       = '0;
        fetch_start_hw = '0;
        pd_rdy         = 1'b1;

        // Model pinned against hand-derived values.
        e = model(32'h100, {16'h0001, 16'h0200, 16'h00EF, 16'h0001}, 0, 0, '0, '0, npf, nph, nppc);
        chk("pin_jal_mask", 64'(e.mask), 64'h3);
        chk("pin_jal_tgt", 64'(e.cf_tgt), 64'h122);
        e = model(32'h700, {16'h0001, 16'h0001, 16'hBFFD, 16'h0001}, 0, 0, '0, '0, npf, nph, nppc);
        chk("pin_cj_imm", 64'(e.cf_imm), 64'hFFFF_FFFE);
        e = model(32'h200, {16'h0013, 16'h0001, 16'h0001, 16'h0001}, 0, 0, '0, '0, npf, nph, nppc);
        chk("pin_straddle_pend", 64'({npf, nppc}), 64'h1_0000_0206);

        repeat (3) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        chk("reset_pd_vld", 64'(pd_vld), 64'(0));
        chk("reset_outputs", 64'({pd_start_mask, pd_cf_vld, pd_carry_vld, pd_pc}), 64'(0));
        next_cycle();
        cpurst = 1'b0;
        next_cycle();

        send(32'h100, {4{16'h0001}}, 2'd0);
        @(negedge forever_cpuclk);
        chk("t1_latency_vld", 64'(pd_vld), 64'(1));
        chk("t1_mask", 64'(pd_start_mask), 64'hF);
        chk("t1_cf_vld", 64'(pd_cf_vld), 64'(0));
        next_cycle();

        send(32'h100, {16'h0001, 16'h0200, 16'h00EF, 16'h0001}, 2'd0);
        @(negedge forever_cpuclk);
        chk("t2_mask", 64'(pd_start_mask), 64'h3);
        chk("t2_cf", 64'({pd_cf_idx, pd_cf_type, pd_cf_inst32}), 64'({2'd1, 3'd3, 1'b1}));
        chk("t2_imm", 64'(pd_cf_imm), 64'h20);
        chk("t2_tgt", 64'(pd_cf_tgt), 64'h122);
        next_cycle();

        send(32'h200, {16'h0013, 16'h0001, 16'h0001, 16'h0001}, 2'd0);
        @(negedge forever_cpuclk);
        chk("t3a_mask", 64'(pd_start_mask), 64'h7);
        next_cycle();
        send(32'h208, {16'h0001, 16'h0001, 16'h0001, 16'h0000}, 2'd0);
        @(negedge forever_cpuclk);
        chk("t3b_carry_vld", 64'(pd_carry_vld), 64'(1));
        chk("t3b_carry_inst", 64'(pd_carry_inst), 64'h13);
        chk("t3b_mask", 64'(pd_start_mask), 64'hE);
        next_cycle();

        send(32'h300, {16'h0013, 16'h0001, 16'h0001, 16'h0001}, 2'd0);
        send(32'h308, {16'h0001, 16'h0001, 16'h0001, 16'h0000}, 2'd2);
        @(negedge forever_cpuclk);
        chk("t4_carry_dropped", 64'(pd_carry_vld), 64'(0));
        chk("t4_mask", 64'(pd_start_mask), 64'hC);
        next_cycle();

        send(32'h400, {16'h00EF, 16'h0001, 16'h0001, 16'h0001}, 2'd0);
        send(32'h408, {16'h0001, 16'h0001, 16'h0001, 16'h0200}, 2'd0);
        @(negedge forever_cpuclk);
        chk("t5_carry_cf", 64'({pd_cf_vld, pd_cf_carry, pd_cf_idx, pd_start_mask}), 64'({1'b1, 1'b1, 2'd0, 4'h0}));
        chk("t5_tgt", 64'(pd_cf_tgt), 64'h426);
        next_cycle();

        send(32'h500, {16'hBFFD, 16'hC401, 16'h0001, 16'h8082}, 2'd1);
        @(negedge forever_cpuclk);
        chk("t6_mask", 64'(pd_start_mask), 64'h6);
        chk("t6_tgt", 64'(pd_cf_tgt), 64'h50C);
        next_cycle();

        send(32'h600, {16'h0001, 16'h0001, 16'h0001, 16'h9282}, 2'd0);
        send(32'h700, {16'h0001, 16'h0001, 16'hBFFD, 16'h0001}, 2'd0);
        @(negedge forever_cpuclk);
        chk("t8_tgt", 64'(pd_cf_tgt), 64'h700);
        next_cycle();
        send(32'h800, {16'h0001, 16'h0001, 16'hFE00, 16'h08E3}, 2'd0);
        @(negedge forever_cpuclk);
        chk("t9_tgt", 64'(pd_cf_tgt), 64'h7F0);
        next_cycle();
        send(32'h900, {16'h0001, 16'h0000, 16'h8067, 16'h0001}, 2'd0);
        send(32'hA00, {16'h0001, 16'h8082, 16'h0002, 16'h8067}, 2'd0);
        @(negedge forever_cpuclk);
        chk("t11_ret16", 64'({pd_start_mask, pd_cf_idx, pd_cf_type, pd_cf_inst32}), 64'({4'h5, 2'd2, 3'd4, 1'b0}));
        next_cycle();

        // Stall: downstream holds pd_rdy low with a packet waiting.
        pd_rdy = 1'b0;
        send(32'hB00, {4{16'h0001}}, 2'd0);
        fetch_pc       = 32'hB08;
        fetch_data     = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
        fetch_start_hw = 2'd0;
        fetch_vld      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge forever_cpuclk);
            chk("stall_fetch_rdy", 64'(fetch_rdy), 64'(0));
            chk("stall_pd_pc", 64'(pd_pc), 64'hB00);
        end
        next_cycle();
        pd_rdy = 1'b1;
        send(32'hB08, {4{16'h0001}}, 2'd0);
        @(negedge forever_cpuclk);
        chk("stall_next_pc", 64'(pd_pc), 64'hB08);
        next_cycle();

        // Flush with an entry held and a pending half stored.
        pd_rdy = 1'b0;
        send(32'hC00, {16'h0013, 16'h0001, 16'h0001, 16'h0001}, 2'd0);
        fetch_pc   = 32'hC08;
        fetch_data = {16'h0001, 16'h0001, 16'h0001, 16'h0000};
        fetch_vld  = 1'b1;
        ifu_flush  = 1'b1;
        next_cycle();
        ifu_flush = 1'b0;
        fetch_vld = 1'b0;
        pd_rdy    = 1'b1;
        @(negedge forever_cpuclk);
        chk("flush_pd_vld", 64'(pd_vld), 64'(0));
        chk("flush_outputs", 64'({pd_start_mask, pd_carry_vld, pd_pc}), 64'(0));
        next_cycle();
        send(32'hC08, {16'h0001, 16'h0001, 16'h0001, 16'h0000}, 2'd0);
        @(negedge forever_cpuclk);
        chk("flush_no_carry", 64'(pd_carry_vld), 64'(0));
        chk("flush_mask", 64'(pd_start_mask), 64'hF);
        next_cycle();

        repeat (3) next_cycle();
        @(negedge forever_cpuclk);
        chk("drained", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
